// File: rtl/seq_deser_8b_valrdy_if.sv
// Handshake bundle for seq_deser_8b_valrdy: serial bit input side and parallel word output side.
interface seq_deser_8b_valrdy_if;
    logic       in_val;
    logic       in_rdy;
    logic       sin;
    logic       out_val;
    logic       out_rdy;
    logic [7:0] out_data;

    modport master (
        output in_val,
        output sin,
        output out_rdy,
        input  in_rdy,
        input  out_val,
        input  out_data
    );

    modport slave (
        input  in_val,
        input  sin,
        input  out_rdy,
        output in_rdy,
        output out_val,
        output out_data
    );
endinterface

// File: rtl/seq_deser_8b_valrdy.sv
// Serial-to-parallel 8-bit deserializer with valid/ready on both sides.
// Define SEQ_DESER_8B_VALRDY_LSB_FIRST_EN for LSB-first bit order (default MSB-first).
module seq_deser_8b_valrdy (
    input  logic                        clk,
    input  logic                        reset,
    seq_deser_8b_valrdy_if.slave        bus
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t     r_state;
    logic [7:0] r_sreg;
    logic [2:0] r_cnt;
    logic [7:0] r_buf;

    logic       w_last_bit;
    logic       w_in_rdy;
    logic       w_in_xfer;
    logic       w_done;
    logic [7:0] w_sreg_next;

    assign w_last_bit = (r_cnt == 3'd7);
    // Only a completing bit can be stalled, and only while the buffer cannot drain.
    assign w_in_rdy   = !(w_last_bit && (r_state == ST_FULL) && !bus.out_rdy);
    assign w_in_xfer  = bus.in_val && w_in_rdy;
    assign w_done     = w_in_xfer && w_last_bit;

`ifdef SEQ_DESER_8B_VALRDY_LSB_FIRST_EN
    assign w_sreg_next = {bus.sin, r_sreg[7:1]};
`else
    assign w_sreg_next = {r_sreg[6:0], bus.sin};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
            r_sreg  <= 8'd0;
            r_cnt   <= 3'd0;
            r_buf   <= 8'd0;
        end else begin
            if (w_in_xfer) begin
                r_sreg <= w_sreg_next;
                r_cnt  <= r_cnt + 3'd1;
            end
            case (r_state)
                ST_EMPTY: begin
                    if (w_done) begin
                        r_buf   <= w_sreg_next;
                        r_state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    // A completion here implies out_rdy=1, so the old word is consumed this edge.
                    if (w_done) begin
                        r_buf   <= w_sreg_next;
                        r_state <= ST_FULL;
                    end else if (bus.out_rdy) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    assign bus.in_rdy   = w_in_rdy;
    assign bus.out_val  = (r_state == ST_FULL);
    assign bus.out_data = r_buf;

endmodule

// File: doc/seq_deser_8b_valrdy.md
SEQ_DESER_8B_VALRDY -- requirements
Module: seq_deser_8b_valrdy

Interface
REQ-001: clk  input  1  single clock; all state updates on the rising edge.
REQ-002: reset  input  1  synchronous, active-high reset.
REQ-003: in_val  input  1  serial bit on sin is valid this cycle.
REQ-004: in_rdy  output  1  block can accept a serial bit this cycle.
REQ-005: sin  input  1  serial data bit; sampled only on an input transfer (in_val && in_rdy).
REQ-006: out_val  output  1  out_data holds a complete word.
REQ-007: out_rdy  input  1  consumer accepts the word this cycle.
REQ-008: out_data  output  8  assembled parallel word.

Function
REQ-009: The block SHALL contain an 8-bit shift register, a 3-bit bit counter (0..7), an 8-bit output buffer and a 2-state FSM {EMPTY, FULL}; out_val SHALL be 1 exactly in FULL.
REQ-010: On each input transfer, the shift register SHALL shift left with sin entering bit 0 (MSB-first order), and the counter SHALL increment by 1 modulo 8.
REQ-011: When an input transfer occurs with counter==7, the completed word {sreg[6:0], sin} SHALL be written into the output buffer, and the block SHALL enter FULL on the next edge.
REQ-012: The latency SHALL be 1 cycle: out_val rises in the cycle after the 8th bit is accepted.
REQ-013: An output transfer (out_val && out_rdy) with no simultaneous word completion SHALL return the FSM to EMPTY.
REQ-014: A word completion coinciding with an output transfer SHALL load the new word and keep out_val=1, with no bubble.
REQ-015: in_rdy SHALL be combinationally !(counter==7 && out_val && !out_rdy); in_rdy SHALL be 1 in all other cases, including for partial-word bits while FULL.
REQ-016: While out_val=1 and out_rdy=0, out_data SHALL remain stable.
REQ-017: In EMPTY, out_data SHALL hold the last delivered word; it is 0 after reset.
REQ-018: in_val=0 cycles SHALL leave the shift register and counter unchanged; gaps of any length are legal.
REQ-019: sin SHALL be ignored when there is no input transfer.

Reset
REQ-020: On reset, the shift register, counter and out_data SHALL become 0, the FSM SHALL enter EMPTY (out_val=0), and in_rdy SHALL read 1.
REQ-021: Reset mid-word SHALL discard all partial bits; the next accepted bit SHALL be bit 1 of a new word.
REQ-022: Reset while FULL SHALL drop the pending word regardless of out_rdy.
REQ-023: Reset SHALL take priority over all simultaneous transfers.

Configuration
REQ-024: The macro is SEQ_DESER_8B_VALRDY_LSB_FIRST_EN.
REQ-025: When the macro is defined, the register SHALL shift right with sin entering bit 7, so the first accepted bit lands in out_data[0].
REQ-026: When the macro is undefined, the behaviour SHALL be MSB-first per REQ-010.
REQ-027: All handshake, latency and reset behaviour SHALL be identical with and without the macro.

Verification
REQ-028: Single word: after reset, out_rdy=1, in_val=1, sin=1,0,1,0,1,0,1,0 -> out_val=1 with out_data=0xAA in the cycle after the 8th bit, then out_val=0 (with the macro: 0x55).
REQ-029: Back-to-back: out_rdy=1, 16 bits forming 0xF0 then 0x0F -> out_val stays 1 in both words' cycles with no gap; in_rdy stays 1 throughout.
REQ-030: Backpressure: out_rdy=0, in_val=1, 15 bits of 1 -> first word 0xFF held, in_rdy=0 at counter==7; raising out_rdy -> 0xFF consumed and the second 0xFF loaded in the same edge.
REQ-031: Gaps: word 0x3C sent with in_val toggling 1,0,1,0... -> out_data=0x3C once all 8 bits are accepted; counter and register are unchanged during in_val=0.
REQ-032: Reset mid-word: 5 bits of 1, reset for 1 cycle, then 8 bits 0,0,0,0,0,0,0,1 -> out_data=0x01, not contaminated by the earlier bits.
REQ-033: Random: 200 cycles of random in_val, sin and out_rdy compared against a golden model -> all outputs match every cycle.
